// File: rtl/rtl_operand_fifo.sv
// rtl_operand_fifo
// Operand-staging FIFO in front of RTL. Producer pairs are accepted over a
// valid/ready interface, buffered in a DEPTH-entry circular buffer, and the
// head pair is presented to RTL on in1/in2 with handshake_valid. Every output
// comes straight from registers, so there is no path from handshake_ready
// back to enq_ready. xfer_count is a free-running, wrapping debug count of
// completed downstream transfers.
module rtl_operand_fifo #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [WIDTH-1:0]           enq_in1,
    input  logic [WIDTH-1:0]           enq_in2,
    output logic [WIDTH-1:0]           in1,
    output logic [WIDTH-1:0]           in2,
    output logic                       handshake_valid,
    input  logic                       handshake_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_WIDTH-1:0]       xfer_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_in1 [DEPTH];
    logic [WIDTH-1:0] mem_in2 [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_enq;
    logic             do_deq;

    // Handshake qualification: both sides only look at registered occupancy.
    // A full FIFO refuses the producer even if the head leaves this cycle.
    always_comb begin
        enq_ready       = (occ != OCC_W'(DEPTH));
        handshake_valid = (occ != '0);
        do_enq          = enq_valid && enq_ready;
        do_deq          = handshake_valid && handshake_ready;
    end

    // Head entry is shown even when empty; storage is cleared on reset so it
    // is never X, and it is not overwritten while occupied.
    always_comb begin
        in1   = mem_in1[rd_ptr];
        in2   = mem_in2[rd_ptr];
        count = occ;
    end

    // Storage write: the slot at wr_ptr is free whenever an enqueue happens.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_in1[i] <= '0;
                mem_in2[i] <= '0;
            end
        end else if (do_enq) begin
            mem_in1[wr_ptr] <= enq_in1;
            mem_in2[wr_ptr] <= enq_in2;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous enqueue and dequeue leave it unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            occ <= '0;
        end else begin
            case ({do_enq, do_deq})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Debug transfer counter, wraps without saturating.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            xfer_count <= '0;
        end else if (do_deq) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rtl_operand_fifo.sv
// Testbench for rtl_operand_fifo: directed scenarios followed by random
// traffic. The driver keeps a reference FIFO as a plain queue and pushes each
// accepted pair onto it; a negedge monitor compares the DUT against it.
module tb_rtl_operand_fifo;

    localparam int WIDTH     = 4;
    localparam int DEPTH     = 2;
    localparam int CNT_WIDTH = 8;

    logic                   CLK = 1'b0;
    logic                   RESET = 1'b1;
    logic                   enq_valid = 1'b0;
    logic                   enq_ready;
    logic [WIDTH-1:0]       enq_in1 = '0;
    logic [WIDTH-1:0]       enq_in2 = '0;
    logic [WIDTH-1:0]       in1;
    logic [WIDTH-1:0]       in2;
    logic                   handshake_valid;
    logic                   handshake_ready = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_WIDTH-1:0]   xfer_count;

    int tests  = 0;
    int failed = 0;

    // reference state: queue of pairs currently buffered (plus pending push)
    logic [2*WIDTH-1:0] exp_q[$];
    int mcount   = 0;
    int mcount_n = 0;
    int mxfer    = 0;
    int mxfer_n  = 0;

    rtl_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_in1         (enq_in1),
        .enq_in2         (enq_in2),
        .in1             (in1),
        .in2             (in2),
        .handshake_valid (handshake_valid),
        .handshake_ready (handshake_ready),
        .count           (count),
        .xfer_count      (xfer_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model decides what the next edge does.
    task automatic step(input bit rst, input bit ev, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit rdy, output bit acc);
        bit deq;
        @(posedge CLK);
        mcount = mcount_n;
        mxfer  = mxfer_n;
        #1;
        RESET           = rst;
        enq_valid       = ev;
        enq_in1         = a;
        enq_in2         = b;
        handshake_ready = rdy;
        acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            mcount_n = 0;
            mxfer_n  = 0;
        end else begin
            acc = ev && (mcount != DEPTH);
            deq = (mcount != 0) && rdy;
            if (acc) exp_q.push_back({a, b});
            mcount_n = mcount + int'(acc) - int'(deq);
            if (deq) mxfer_n = mxfer + 1;
        end
    endtask

    // Monitor: checks state every cycle and pops the scoreboard on transfers.
    always @(negedge CLK) begin
        if (!RESET) begin
            chk("count", 32'(count), 32'(mcount));
            chk("enq_ready", 32'(enq_ready), 32'(mcount != DEPTH));
            chk("handshake_valid", 32'(handshake_valid), 32'(mcount != 0));
            chk("xfer_count", 32'(xfer_count), 32'(mxfer % (1 << CNT_WIDTH)));
            if (mcount != 0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL scoreboard_empty: model holds %0d but queue empty", mcount);
                end else begin
                    chk("head_in1", 32'(in1), 32'(exp_q[0][2*WIDTH-1:WIDTH]));
                    chk("head_in2", 32'(in2), 32'(exp_q[0][WIDTH-1:0]));
                    if (handshake_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit acc;
        int got;
        logic [WIDTH-1:0] v;

        // 1: reset held two cycles with enq_valid high
        step(1, 1, 4'h3, 4'h3, 0, acc);
        step(1, 1, 4'h3, 4'h3, 0, acc);
        step(0, 0, 4'h0, 4'h0, 0, acc);
        @(negedge CLK);
        chk("reset_in1", 32'(in1), 32'h0);
        chk("reset_in2", 32'(in2), 32'h0);

        // 2: single pair, held, then consumed
        step(0, 1, 4'hA, 4'h5, 0, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 4'h0, 0, acc);
        step(0, 0, 4'h0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 4'h0, 0, acc);
        @(negedge CLK);
        chk("single_xfer", 32'(xfer_count), 32'd1);

        // 3/4: fill, refusal while full, simultaneous at full, then both
        step(0, 1, 4'h3, 4'h1, 0, acc);
        step(0, 1, 4'h7, 4'h2, 0, acc);
        step(0, 1, 4'h9, 4'h4, 0, acc);
        step(0, 1, 4'h9, 4'h4, 1, acc);
        step(0, 1, 4'h9, 4'h4, 1, acc);
        step(0, 0, 4'h0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 4'h0, 0, acc);

        // 5: streaming long enough to wrap xfer_count
        for (int i = 0; i < 300; i++)
            step(0, 1, WIDTH'(i), WIDTH'($urandom), 1, acc);
        step(0, 0, 4'h0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 4'h0, 0, acc);

        // 6: reset with the FIFO full, then a fresh pair
        step(0, 1, 4'hC, 4'hD, 0, acc);
        step(0, 1, 4'hE, 4'hF, 0, acc);
        step(1, 1, 4'h1, 4'h1, 1, acc);
        step(0, 0, 4'h0, 4'h0, 0, acc);
        @(negedge CLK);
        chk("flush_valid", 32'(handshake_valid), 32'h0);
        chk("flush_count", 32'(count), 32'h0);
        step(0, 1, 4'h6, 4'h2, 0, acc);
        step(0, 0, 4'h0, 4'h0, 0, acc);
        @(negedge CLK);
        chk("after_flush_in1", 32'(in1), 32'h6);
        step(0, 0, 4'h0, 4'h0, 1, acc);

        // random traffic with occasional resets
        got = 0;
        for (int i = 0; i < 600; i++) begin
            v = WIDTH'($urandom);
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), v,
                 WIDTH'($urandom), ($urandom_range(0, 2) != 0), acc);
            if (acc) got++;
        end
        step(0, 0, 4'h0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 4'h0, 1, acc);
        step(0, 0, 4'h0, 4'h0, 1, acc);
        @(negedge CLK);
        chk("final_count", 32'(count), 32'h0);
        chk("final_queue", 32'(exp_q.size()), 32'(mcount));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rtl_operand_fifo.md
# rtl_operand_fifo

Operand-staging stage that sits directly upstream of `RTL` and drives its `in1`, `in2` and `handshake_valid` inputs while consuming its `handshake_ready`. It accepts operand pairs from the producer over a valid/ready interface and buffers them in a DEPTH-entry FIFO. It presents the head pair to `RTL` under the ready/valid rules that `RTL`'s bound assertion monitor checks. It also keeps an occupancy output and a wrapping count of completed transfers for debug.

## Interface
- `WIDTH`, default 4: bit width of each operand. Must match `RTL`'s `in1`/`in2`.
- `DEPTH`, default 2: FIFO entries. Power of two, at least 2.
- `CNT_WIDTH`, default 8: width of `xfer_count`.

Ports:
- `CLK`, input, 1: single clock; all state updates on the rising edge.
- `RESET`, input, 1: synchronous, active-high reset.
- `enq_valid`, input, 1: producer presents a pair.
- `enq_ready`, output, 1: FIFO can accept a pair this cycle.
- `enq_in1`, input, WIDTH: producer operand 1.
- `enq_in2`, input, WIDTH: producer operand 2.
- `in1`, output, WIDTH: head operand 1, to `RTL.in1`.
- `in2`, output, WIDTH: head operand 2, to `RTL.in2`.
- `handshake_valid`, output, 1: head entry valid, to `RTL.handshake_valid`.
- `handshake_ready`, input, 1: from `RTL.handshake_ready`.
- `count`, output, log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `xfer_count`, output, CNT_WIDTH: completed downstream transfers, modulo 2^CNT_WIDTH.

## Operation
- **Storage.** Circular buffer with `wr_ptr`, `rd_ptr` and `count` registers.
  - Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
  - `count` is the authoritative full/empty indicator.
- **Enqueue.** Occurs when `enq_valid && enq_ready`.
  - `enq_ready = (count != DEPTH)`, driven only from registered state.
  - There is no combinational path from `handshake_ready` to `enq_ready`.
  - When full, enqueue is refused even if a dequeue happens in the same cycle.
- **Dequeue.** Occurs when `handshake_valid && handshake_ready`.
  - `handshake_valid = (count != 0)`.
  - `in1`/`in2` equal the entry at `rd_ptr`.
- **Count update.**
  - Enqueue only: `count+1`.
  - Dequeue only: `count-1`.
  - Both in the same cycle: `count` unchanged, both pointers advance.
  - Neither: no change.
- **Empty.** `handshake_valid` = 0. `in1`/`in2` are don't-care but must not be X; they show the stale entry at `rd_ptr`.
- **Downstream stability.** Once `handshake_valid` rises, it stays 1 and `in1`/`in2` stay unchanged until the cycle a dequeue occurs. This holds by construction, since the head entry is never overwritten while `count != 0`.
- **Transfer counter.** `xfer_count` increments by 1 on every dequeue and wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- **Reset.** While `RESET` is high at a clock edge:
  - `count`, `wr_ptr`, `rd_ptr`, `xfer_count` and all storage entries clear to 0.
  - Any enqueue or dequeue in that cycle is discarded.
  - Reset mid-operation flushes all buffered pairs.

## Timing
- Reset values, valid in the cycle after reset is sampled:
  - `enq_ready` = 1
  - `handshake_valid` = 0
  - `in1` = `in2` = 0
  - `count` = 0
  - `xfer_count` = 0
- Enqueue-to-present latency is 1 cycle. A pair accepted at edge N appears on `in1`/`in2` with `handshake_valid` = 1 after edge N, if the FIFO was empty. There is no same-cycle bypass.
- Full throughput is 1 pair per cycle when `count` is between 1 and DEPTH-1 and both sides are active.
- All outputs are functions of registers only.
- `handshake_ready` and `enq_valid` may toggle freely. `handshake_ready` asserted while `handshake_valid` = 0 has no effect.

## Test plan
1. **Reset.** Assert `RESET` for 2 cycles with `enq_valid` = 1.
   - `count` = 0, `handshake_valid` = 0, `enq_ready` = 1, `xfer_count` = 0 after deassert.
2. **Single pass.** Enqueue (`enq_in1`=4'hA, `enq_in2`=4'h5) with `handshake_ready` = 0.
   - Next cycle: `handshake_valid` = 1, `in1` = A, `in2` = 5, `count` = 1.
   - Hold 3 cycles: outputs unchanged.
   - Raise ready: dequeue, `count` = 0, `xfer_count` = 1.
3. **Full and order.** Enqueue 3, 7, 9 on `in1` back-to-back with `handshake_ready` = 0.
   - `enq_ready` drops after the 2nd enqueue; 9 is not accepted while full.
   - Drain: `in1` sequence 3, then 7.
   - 9 is accepted after the first dequeue frees a slot.
4. **Simultaneous at full.** `count` = 2, `enq_valid` = 1, `handshake_ready` = 1.
   - Dequeue only, enqueue refused; `count` = 1.
   - Next cycle with the same stimulus: both occur, `count` stays 1.
5. **Streaming and wrap.** Keep `enq_valid` and `handshake_ready` high for 300 cycles with an incrementing `enq_in1`.
   - Pairs arrive in order with no loss or duplication.
   - `xfer_count` wraps 255 → 0 and ends at (transfers mod 256).
6. **Reset mid-operation.** `count` = 2, then pulse `RESET` for 1 cycle.
   - `handshake_valid` = 0 and `count` = 0 next cycle.
   - A subsequent enqueue of 4'h6 appears as `in1` = 6, with no stale data presented.
